// File: rtl/embedding_fetcher.sv
// Walks a token-ID RAM and, for every nonzero token, copies that token's
// embedding row from the embedding SRAM into the activation buffer.
module embedding_fetcher #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int EMB_DIM        = 4,
  parameter int EMB_ADDR_WIDTH = 8,
  parameter int OUT_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cs,
  output logic [ADDR_WIDTH-1:0]     tok_addr,
  input  logic [DATA_WIDTH-1:0]     tok_data,
  output logic [EMB_ADDR_WIDTH-1:0] emb_addr,
  input  logic [DATA_WIDTH-1:0]     emb_data,
  output logic [OUT_ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_we,
  output logic [ADDR_WIDTH:0]       tok_count,
  output logic                      busy,
  output logic                      done
);

  // state     | meaning
  // S_IDLE    | waiting for cs; token index held at 0
  // S_TOK_RD  | token RAM address presented
  // S_TOK_CHK | token word valid; 0 terminates, else latch row base
  // S_EMB_RD  | issue EMB_DIM embedding reads, one per cycle
  // S_DRAIN   | last row write lands; advance to next token
  // S_DONE    | run finished; waits for cs to drop

  localparam int JW = $clog2(EMB_DIM);

  if (EMB_DIM < 2 || (1 << JW) != EMB_DIM) begin : g_bad_dim
    $error("embedding_fetcher: EMB_DIM must be a power of two >= 2");
  end
  if (OUT_ADDR_WIDTH < ADDR_WIDTH + JW) begin : g_bad_out
    $error("embedding_fetcher: OUT_ADDR_WIDTH too small for all rows");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_TOK_RD, S_TOK_CHK, S_EMB_RD, S_DRAIN, S_DONE
  } state_t;

  state_t                    state, state_nxt;
  logic [ADDR_WIDTH-1:0]     tok_idx;
  logic [JW-1:0]             j;
  logic [EMB_ADDR_WIDTH-1:0] emb_base;
  logic                      last_j;
  logic                      last_tok;

  assign last_j   = (j == JW'(EMB_DIM - 1));
  assign last_tok = (tok_idx == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cs) state_nxt = S_TOK_RD;
      S_TOK_RD:  state_nxt = S_TOK_CHK;
      S_TOK_CHK: state_nxt = (tok_data == '0) ? S_DONE : S_EMB_RD;
      S_EMB_RD:  if (last_j) state_nxt = S_DRAIN;
      S_DRAIN:   state_nxt = last_tok ? S_DONE : S_TOK_RD;
      S_DONE:    if (!cs) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_idx   <= '0;
      j         <= '0;
      emb_base  <= '0;
      out_addr  <= '0;
      out_we    <= 1'b0;
      tok_count <= '0;
    end else begin
      // A write is pending for the cycle after every embedding read issue.
      out_we <= (state == S_EMB_RD);
      case (state)
        S_IDLE: begin
          tok_idx <= '0;
          if (cs) tok_count <= '0;
        end
        S_TOK_CHK: begin
          emb_base <= EMB_ADDR_WIDTH'({tok_data, {JW{1'b0}}});
          j        <= '0;
        end
        S_EMB_RD: begin
          j        <= j + JW'(1);
          out_addr <= OUT_ADDR_WIDTH'({tok_idx, j});
        end
        S_DRAIN: begin
          tok_count <= tok_count + 1'b1;
          if (!last_tok) tok_idx <= tok_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign tok_addr = (state == S_TOK_RD) ? tok_idx : '0;
  assign emb_addr = (state == S_EMB_RD) ? emb_base + EMB_ADDR_WIDTH'(j) : '0;
  assign out_data = emb_data;
  assign busy     = (state == S_TOK_RD) || (state == S_TOK_CHK) ||
                    (state == S_EMB_RD) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_embedding_fetcher.sv
// Bench for embedding_fetcher: directed and random token tables checked
// against a row-copy reference model including write timing.
module tb_embedding_fetcher;
  localparam int AW = 4, DW = 8, D = 4, EAW = 8, OAW = 8;
  localparam int NTOK = 1 << AW;
  localparam int COST = D + 3;

  logic clk = 1'b0, rst_n = 1'b0, cs = 1'b0;
  logic [AW-1:0]  tok_addr;
  logic [DW-1:0]  tok_data = '0, emb_data = '0, out_data;
  logic [EAW-1:0] emb_addr;
  logic [OAW-1:0] out_addr;
  logic           out_we, busy, done;
  logic [AW:0]    tok_count;

  logic [DW-1:0] tok_mem [NTOK];
  logic [DW-1:0] emb_mem [1 << EAW];

  int n_checks = 0, n_fail = 0, cyc = 0;
  int wq_addr[$], wq_data[$], wq_cyc[$];

  embedding_fetcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .EMB_DIM(D),
                      .EMB_ADDR_WIDTH(EAW), .OUT_ADDR_WIDTH(OAW)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .tok_addr(tok_addr), .tok_data(tok_data),
    .emb_addr(emb_addr), .emb_data(emb_data), .out_addr(out_addr),
    .out_data(out_data), .out_we(out_we), .tok_count(tok_count),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  // Memories with one-cycle registered read, plus the activation-buffer capture.
  always @(posedge clk) begin
    tok_data <= tok_mem[tok_addr];
    emb_data <= emb_mem[emb_addr];
    cyc <= cyc + 1;
    if (out_we) begin
      wq_addr.push_back(int'(out_addr));
      wq_data.push_back(int'(out_data));
      wq_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_emb_linear();
    for (int k = 0; k < (1 << EAW); k++) emb_mem[k] = DW'(k + 16);
  endtask

  task automatic clear_tok();
    for (int k = 0; k < NTOK; k++) tok_mem[k] = '0;
  endtask

  // Cycles are counted from the cycle in which idle samples cs high (cycle 0).
  task automatic run_and_check(input string tag, input int hold);
    int exp_addr[$], exp_data[$], exp_cyc[$];
    int n_rows = 0, done_cyc, start, got_done = -1, nw;
    bit term = 0;
    for (int i = 0; i < NTOK && !term; i++) begin
      if (tok_mem[i] == 0) term = 1;
      else begin
        for (int e = 0; e < D; e++) begin
          exp_addr.push_back(i * D + e);
          exp_data.push_back(int'(emb_mem[(int'(tok_mem[i]) * D + e) % (1 << EAW)]));
          exp_cyc.push_back(1 + i * COST + 3 + e);
        end
        n_rows++;
      end
    end
    done_cyc = 1 + n_rows * COST + (term ? 2 : 0);
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    @(negedge clk);
    cs = 1'b1;
    start = cyc;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cyc - start == 1) begin
        chk({tag, " first tok_addr"}, int'(tok_addr), 0);
        chk({tag, " busy in run"}, int'(busy), 1);
      end
      if (done) begin
        got_done = cyc - start;
        break;
      end
    end
    chk({tag, " done cycle"}, got_done, done_cyc);
    chk({tag, " tok_count"}, int'(tok_count), n_rows);
    chk({tag, " busy at done"}, int'(busy), 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " held done"}, int'(done), 1);
      chk({tag, " held tok_addr"}, int'(tok_addr) + int'(busy), 0);
    end
    cs = 1'b0;
    nw = wq_addr.size();
    chk({tag, " write count"}, nw, exp_addr.size());
    for (int w = 0; w < nw && w < exp_addr.size(); w++) begin
      chk($sformatf("%s w%0d addr", tag, w), wq_addr[w], exp_addr[w]);
      chk($sformatf("%s w%0d data", tag, w), wq_data[w], exp_data[w]);
      chk($sformatf("%s w%0d cycle", tag, w), wq_cyc[w] - start, exp_cyc[w]);
    end
  endtask

  initial begin
    int start;
    clear_tok();
    fill_emb_linear();
    #12;
    chk("reset out_we", int'(out_we), 0);
    chk("reset busy/done", int'(busy) + int'(done), 0);
    chk("reset tok_count", int'(tok_count), 0);
    @(negedge clk) rst_n = 1'b1;

    tok_mem[0] = 3; tok_mem[1] = 1;
    run_and_check("two_tokens", 0);

    clear_tok();
    run_and_check("empty", 0);

    for (int k = 0; k < NTOK; k++) tok_mem[k] = 1;
    run_and_check("full_no_term", 0);

    clear_tok();
    tok_mem[0] = 255;
    run_and_check("wrap", 0);

    // Reset pulsed during the second write of token 0.
    clear_tok();
    tok_mem[0] = 3; tok_mem[1] = 1;
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
    @(negedge clk);
    cs = 1'b1;
    start = cyc;
    for (int k = 0; k < 20 && cyc != start + 5; k++) begin
      @(posedge clk);
      #1;
    end
    chk("rst second write we", int'(out_we), 1);
    rst_n = 1'b0;
    #1;
    chk("rst out_we", int'(out_we), 0);
    chk("rst addrs", int'(tok_addr) + int'(emb_addr) + int'(out_addr), 0);
    chk("rst count/busy/done", int'(tok_count) + int'(busy) + int'(done), 0);
    @(negedge clk);
    cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst writes landed", wq_addr.size(), 1);
    run_and_check("after_reset", 0);

    run_and_check("held_cs", 10);
    run_and_check("rerun", 0);

    for (int r = 0; r < 6; r++) begin
      int term_at;
      for (int k = 0; k < (1 << EAW); k++) emb_mem[k] = DW'($urandom);
      term_at = $urandom_range(0, NTOK);
      for (int k = 0; k < NTOK; k++)
        tok_mem[k] = (k == term_at) ? '0 : DW'($urandom_range(1, 255));
      run_and_check($sformatf("rand%0d", r), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
